// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell is reused over WIDTH cycles, LSB first,
// with a carry flip-flop linking consecutive slices. Start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg, sr_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             fa_s, fa_cout;
  logic             last_slice;
  logic [WIDTH-1:0] sr_next;

  full_adder u_fa (
    .a    (sa_reg[0]),
    .b    (sb_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_slice = (cnt_reg == CW'(WIDTH - 1));
  // New sum bit enters at the MSB so that after WIDTH slices bit 0 holds slice 0.
  assign sr_next    = {fa_s, sr_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg    <= '0;
      sb_reg    <= '0;
      sr_reg    <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            sr_reg    <= '0;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          sr_reg    <= sr_next;
          carry_reg <= fa_cout;
          if (last_slice) begin
            sum_reg  <= sr_next;
            cout_reg <= fa_cout;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random additions
// checked against plain-arithmetic a+b+cin, including handshake timing.

module tb_serial_add_ctrl;
  localparam int W = 8;
  typedef logic [W-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst, start, cin;
  word_t a, b;
  logic  busy, done, cout;
  word_t sum;

  int total = 0;
  int bad   = 0;

  word_t m_sum;
  logic  m_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One addition: start accepted at the next edge, WIDTH RUN cycles, one DONE
  // cycle, then IDLE. inject>=0 pulses a stray start at that RUN cycle index;
  // hold keeps start high with changing operands throughout.
  task automatic run_add(input word_t ta, input word_t tb, input logic tc,
                         input int inject, input bit hold);
    logic [W:0] exp;
    exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    a = ta; b = tb; cin = tc; start = 1'b1;
    step();
    for (int i = 0; i < W; i++) begin
      a   = word_t'($urandom);
      b   = word_t'($urandom);
      cin = 1'($urandom);
      if (!hold) start = (i == inject);
      check("busy_run", {63'd0, busy}, 64'd1);
      check("done_run", {63'd0, done}, 64'd0);
      check("sum_hold", {55'd0, cout, sum}, {55'd0, m_cout, m_sum});
      step();
    end
    if (!hold) start = 1'b0;
    check("done_pulse", {63'd0, done}, 64'd1);
    check("busy_done", {63'd0, busy}, 64'd0);
    check("result", {55'd0, cout, sum}, {55'd0, exp});
    m_sum  = exp[W-1:0];
    m_cout = exp[W];
    step();
    check("done_once", {63'd0, done}, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
    $display("add a=%h b=%h cin=%0d -> expected cout=%0d sum=%h", ta, tb, tc, exp[W], exp[W-1:0]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    m_sum = '0; m_cout = 1'b0;
    step();
    start = 1'b1;
    step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", {56'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    step();

    run_add(8'h5A, 8'h3C, 1'b0, -1, 1'b0);
    check("plan1", {55'd0, cout, sum}, 64'h096);
    run_add(8'hFF, 8'h01, 1'b0, -1, 1'b0);
    check("ripple", {55'd0, cout, sum}, 64'h100);
    run_add(8'hFF, 8'hFF, 1'b1, -1, 1'b0);
    check("max", {55'd0, cout, sum}, 64'h1FF);

    // Stray start in RUN cycle 3; the previous 0x96 must hold meanwhile.
    run_add(8'h5A, 8'h3C, 1'b0, -1, 1'b0);
    run_add(8'h10, 8'h20, 1'b0, 2, 1'b0);
    check("ignored_start", {55'd0, cout, sum}, 64'h030);
    run_add(word_t'($urandom), word_t'($urandom), 1'b1, W - 1, 1'b0);

    // Start held continuously: back-to-back acceptance every WIDTH+2 edges.
    for (int n = 0; n < 4; n++)
      run_add(word_t'($urandom), word_t'($urandom), 1'($urandom), -1, 1'b1);
    start = 1'b0;
    step();

    // Reset in RUN cycle 4 aborts the addition.
    run_add(8'h5A, 8'h3C, 1'b0, -1, 1'b0);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_sum", {55'd0, cout, sum}, 64'd0);
    m_sum = '0; m_cout = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      check("abort_no_done", {63'd0, done}, 64'd0);
      step();
    end
    run_add(8'h01, 8'h01, 1'b0, -1, 1'b0);

    for (int n = 0; n < 24; n++)
      run_add(word_t'($urandom), word_t'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
